// File: rtl/led_fader_if.sv
// Pin-side bundle of the LED fader: pattern request and blink level in, PWM pins and ramp status out.
// dbg_state carries the per-channel DARK/RISING/LIT/FALLING code, 2 bits per channel.
interface led_fader_if;
    logic [5:0]  led_req;
    logic        blink_in;
    logic [5:0]  leds;
    logic        blink;
    logic [5:0]  fading;
    logic [11:0] dbg_state;

    modport master (
        output led_req, blink_in,
        input  leds, blink, fading, dbg_state
    );

    modport slave (
        input  led_req, blink_in,
        output leds, blink, fading, dbg_state
    );
endinterface

// File: rtl/led_fader.sv
// LED output stage: per-channel brightness ramps applied only at PWM frame boundaries, 8-bit PWM pins.
// Define LED_FADER_GAMMA_EN for squared (perceptual) duty with one extra registered stage.
module led_fader #(
    parameter int PRESCALE = 1953,
    parameter int STEP     = 4
) (
    input  logic       clk50,
    input  logic       rst_n,
    led_fader_if.slave bus
);
    typedef enum logic [1:0] {
        ST_DARK    = 2'd0,
        ST_RISING  = 2'd1,
        ST_LIT     = 2'd2,
        ST_FALLING = 2'd3
    } ch_state_e;

    localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);
    localparam logic [7:0]  STEP8         = 8'(STEP);

    logic [15:0]     r_presc;
    logic [7:0]      r_pwm;
    logic [5:0][7:0] r_bright;

    logic            w_tick;
    logic            w_frame;
    logic [5:0][7:0] w_bright_nxt;
    logic [5:0][7:0] w_duty;
    logic [7:0]      w_pwm;
    logic [5:0]      w_led;
    logic [5:0]      w_fading;
    logic [5:0][1:0] w_state;

    assign w_tick  = (r_presc == PRESCALE_LAST);
    assign w_frame = w_tick && (r_pwm == 8'hFF);

    for (genvar g = 0; g < 6; g++) begin : g_ch
        logic [8:0]        w_up;
        logic signed [8:0] w_dn;

        // Sign bit of w_dn flags an underflow below dark.
        assign w_up = {1'b0, r_bright[g]} + {1'b0, STEP8};
        assign w_dn = $signed({1'b0, r_bright[g]}) - $signed({1'b0, STEP8});

        assign w_bright_nxt[g] = bus.led_req[g] ? (w_up[8] ? 8'hFF : w_up[7:0])
                                                : (w_dn[8] ? 8'h00 : w_dn[7:0]);

        assign w_fading[g] = bus.led_req[g] ? (r_bright[g] != 8'hFF) : (r_bright[g] != 8'h00);

        assign w_state[g] = bus.led_req[g]
                          ? ((r_bright[g] == 8'hFF) ? ST_LIT  : ST_RISING)
                          : ((r_bright[g] == 8'h00) ? ST_DARK : ST_FALLING);

        assign w_led[g] = (w_duty[g] == 8'hFF) || (w_pwm < w_duty[g]);
    end

`ifdef LED_FADER_GAMMA_EN
    logic [5:0][7:0] r_duty;
    logic [7:0]      r_pwm_d;
    logic [5:0][7:0] w_gamma;

    for (genvar g = 0; g < 6; g++) begin : g_gamma
        assign w_gamma[g] = (r_bright[g] == 8'hFF) ? 8'hFF
                          : 8'(({8'h00, r_bright[g]} * {8'h00, r_bright[g]}) >> 8);
    end

    // pwm_cnt is delayed alongside duty so the PWM pattern stays aligned to the frame.
    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            r_duty  <= '0;
            r_pwm_d <= '0;
        end else begin
            r_duty  <= w_gamma;
            r_pwm_d <= r_pwm;
        end
    end

    assign w_duty = r_duty;
    assign w_pwm  = r_pwm_d;
`else
    assign w_duty = r_bright;
    assign w_pwm  = r_pwm;
`endif

    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            r_presc       <= '0;
            r_pwm         <= '0;
            r_bright      <= '0;
            bus.leds      <= '0;
            bus.blink     <= 1'b0;
            bus.fading    <= '0;
            bus.dbg_state <= '0;
        end else begin
            r_presc <= w_tick ? 16'd0 : r_presc + 16'd1;
            if (w_tick) begin
                r_pwm <= r_pwm + 8'd1;
            end
            if (w_frame) begin
                r_bright  <= w_bright_nxt;
                bus.blink <= bus.blink_in;
            end
            bus.leds      <= w_led;
            bus.fading    <= w_fading;
            bus.dbg_state <= w_state;
        end
    end
endmodule

// File: tb/tb_led_fader.sv
// Bench for led_fader: two instances (STEP 4 and STEP 100) at PRESCALE 1, measured one PWM frame at a time.
`timescale 1ns/1ps
module tb_led_fader;
    localparam int STEP_A = 4;
    localparam int STEP_B = 100;
`ifdef LED_FADER_GAMMA_EN
    localparam int LAT         = 2;
    localparam int EXP_CH0_W1  = 0;
    localparam int EXP_CH0_W32 = 64;
    localparam int EXP_CH1_W11 = 5;
`else
    localparam int LAT         = 1;
    localparam int EXP_CH0_W1  = 4;
    localparam int EXP_CH0_W32 = 128;
    localparam int EXP_CH1_W11 = 36;
`endif
    localparam int FE_J = 255 - LAT;
    localparam int NW   = 71;
    localparam logic [5:0] GMASK = 6'b000100;

    typedef struct {
        logic req;
        logic blink_in;
        int   exp_bright;
        logic exp_blink;
    } vec_t;

    logic clk50 = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk50 = ~clk50;

    led_fader_if if_a ();
    led_fader_if if_b ();

    led_fader #(.PRESCALE(1), .STEP(STEP_A)) u_a (.clk50(clk50), .rst_n(rst_n), .bus(if_a));
    led_fader #(.PRESCALE(1), .STEP(STEP_B)) u_b (.clk50(clk50), .rst_n(rst_n), .bus(if_b));

    int n_tests = 0;
    int n_fail  = 0;

    vec_t tbl_b[8];
    logic [54:0] exp_qa[$];
    logic [9:0]  exp_qb[$];

    int          br_a[6];
    logic        bl_a;
    int          cnt_a[6];
    int          cnt_b[6];
    logic [5:0]  fad_a;
    logic [11:0] dbg_a;
    logic        blink_a_s;
    logic        blink_b_s;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int duty_of(input int b);
`ifdef LED_FADER_GAMMA_EN
        return (b == 255) ? 255 : (b * b) / 256;
`else
        return b;
`endif
    endfunction

    function automatic int cnt_of(input int b);
        int d;
        d = duty_of(b);
        return (d == 255) ? 256 : d;
    endfunction

    function automatic int ramp(input int b, input logic up, input int step);
        if (up) return (b + step > 255) ? 255 : b + step;
        return (b - step < 0) ? 0 : b - step;
    endfunction

    function automatic logic [54:0] pack_a();
        logic [54:0] e;
        e = '0;
        for (int i = 0; i < 6; i++) e[i*9 +: 9] = 9'(cnt_of(br_a[i]));
        e[54] = bl_a;
        return e;
    endfunction

    // One PWM frame window: 256 samples, plus optional input glitches on DUT a.
    task automatic run_frame(input int mode, input logic [5:0] gmask);
        for (int i = 0; i < 6; i++) begin
            cnt_a[i] = 0;
            cnt_b[i] = 0;
        end
        for (int j = 0; j < 256; j++) begin
            @(posedge clk50);
            @(negedge clk50);
            for (int i = 0; i < 6; i++) begin
                cnt_a[i] += int'(if_a.leds[i]);
                cnt_b[i] += int'(if_b.leds[i]);
            end
            if (j == 0) begin
                blink_a_s = if_a.blink;
                blink_b_s = if_b.blink;
            end
            if (j == 10) begin
                fad_a = if_a.fading;
                dbg_a = if_a.dbg_state;
            end
            if ((mode == 1 && (j == 60 || j == 120)) || (mode == 2 && (j == FE_J || j == FE_J + 1))) begin
                if_a.led_req  = if_a.led_req ^ gmask;
                if_a.blink_in = ~if_a.blink_in;
            end
        end
    endtask

    initial begin
        logic [54:0] ea;
        logic [9:0]  eb;
        logic [5:0]  req_w;
        logic [5:0]  req_f;
        logic [5:0]  fe;
        int          mode;

        tbl_b[0] = '{1'b1, 1'b1, 100, 1'b1};
        tbl_b[1] = '{1'b1, 1'b0, 200, 1'b0};
        tbl_b[2] = '{1'b1, 1'b1, 255, 1'b1};
        tbl_b[3] = '{1'b1, 1'b1, 255, 1'b1};
        tbl_b[4] = '{1'b0, 1'b0, 155, 1'b0};
        tbl_b[5] = '{1'b0, 1'b1,  55, 1'b1};
        tbl_b[6] = '{1'b0, 1'b0,   0, 1'b0};
        tbl_b[7] = '{1'b0, 1'b0,   0, 1'b0};

        rst_n = 1'b0;
        if_a.led_req = 6'h3F; if_a.blink_in = 1'b1;
        if_b.led_req = 6'h3F; if_b.blink_in = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk50);
            @(negedge clk50);
            check($sformatf("rst_leds_c%0d", c), if_a.leds, 0);
            check($sformatf("rst_fading_c%0d", c), if_a.fading, 0);
            check($sformatf("rst_blink_c%0d", c), if_a.blink, 0);
            check($sformatf("rst_leds_b_c%0d", c), if_b.leds, 0);
        end
        rst_n = 1'b1;
        @(posedge clk50);
        @(negedge clk50);
        check("fading_after_release", if_a.fading, 6'h3F);

        rst_n = 1'b0;
        if_a.led_req = 6'h03; if_a.blink_in = 1'b0;
        if_b.led_req = {6{tbl_b[0].req}}; if_b.blink_in = tbl_b[0].blink_in;
        repeat (2) @(posedge clk50);
        @(negedge clk50);
        rst_n = 1'b1;
        if (LAT == 2) begin
            @(posedge clk50);
            @(negedge clk50);
        end

        for (int i = 0; i < 6; i++) br_a[i] = 0;
        bl_a = 1'b0;
        exp_qa.push_back(pack_a());

        for (int w = 0; w < NW; w++) begin
            req_w = (w >= 67) ? 6'h3F : {4'b0000, (w < 10), 1'b1};
            mode  = (w == 30) ? 1 : ((w == 40) ? 2 : 0);
            if_a.led_req  = req_w;
            if_a.blink_in = 1'b0;
            if (w < 8) begin
                if_b.led_req  = {6{tbl_b[w].req}};
                if_b.blink_in = tbl_b[w].blink_in;
                eb = {tbl_b[w].exp_blink, 9'(cnt_of(tbl_b[w].exp_bright))};
                exp_qb.push_back(eb);
            end else begin
                if_b.led_req  = '0;
                if_b.blink_in = 1'b0;
            end

            for (int i = 0; i < 6; i++) fe[i] = req_w[i] ? (br_a[i] != 255) : (br_a[i] != 0);
            req_f = (mode == 2) ? (req_w ^ GMASK) : req_w;
            for (int i = 0; i < 6; i++) br_a[i] = ramp(br_a[i], req_f[i], STEP_A);
            bl_a = (mode == 2);
            exp_qa.push_back(pack_a());

            run_frame(mode, GMASK);

            ea = exp_qa.pop_front();
            for (int i = 0; i < 6; i++)
                check($sformatf("a_cnt_w%0d_ch%0d", w, i), cnt_a[i], ea[i*9 +: 9]);
            check($sformatf("a_blink_w%0d", w), blink_a_s, ea[54]);
            check($sformatf("a_fading_w%0d", w), fad_a, fe);

            if (w >= 1 && w <= 8) begin
                eb = exp_qb.pop_front();
                check($sformatf("b_cnt_ch0_w%0d", w), cnt_b[0], eb[8:0]);
                check($sformatf("b_cnt_ch5_w%0d", w), cnt_b[5], eb[8:0]);
                check($sformatf("b_blink_w%0d", w), blink_b_s, eb[9]);
            end

            if (w == 1)  check("ramp_first_frame", cnt_a[0], EXP_CH0_W1);
            if (w == 11) check("reversal_first_step", cnt_a[1], EXP_CH1_W11);
            if (w == 32) check("half_bright_duty", cnt_a[0], EXP_CH0_W32);
            if (w == 64) begin
                check("full_ramp_on", cnt_a[0], 256);
                check("full_ramp_fading", fad_a[0], 0);
                check("full_ramp_state_lit", dbg_a[1:0], 2'd2);
            end
        end

        // Reset in the middle of ramps must drop every channel back to dark.
        exp_qa.delete();
        rst_n = 1'b0;
        if_a.led_req = '0;
        @(posedge clk50);
        @(negedge clk50);
        check("rst_mid_leds", if_a.leds, 0);
        @(posedge clk50);
        @(negedge clk50);
        rst_n = 1'b1;
        if (LAT == 2) begin
            @(posedge clk50);
            @(negedge clk50);
        end
        run_frame(0, '0);
        for (int i = 0; i < 6; i++) check($sformatf("post_rst_cnt_ch%0d", i), cnt_a[i], 0);
        check("post_rst_fading", fad_a, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/led_fader.md
# led_fader

Output stage between the LED pattern counter and the board LED pins. Takes the 6-bit on/off request pattern and the blink level from the counter stage and drives the pins with 8-bit PWM. Each channel ramps its brightness toward the requested state, one step per PWM frame. Brightness changes only at frame boundaries, so the LEDs fade smoothly and never glitch mid-frame.

## Interface
- PRESCALE, default 1953: clk50 cycles per PWM count, giving about 100 Hz frame rate at 50 MHz; legal range 1..65535.
- STEP, default 4: brightness change per frame; legal range 1..255.
- clk50  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk50.
- led_req  input  6  per-channel target: 1 = ramp to full, 0 = ramp to dark.
- blink_in  input  1  blink level from the counter stage.
- leds  output  6  PWM drive to the LED pins.
- blink  output  1  blink_in re-timed to frame boundaries.
- fading  output  6  per-channel ramp-in-progress flag.

## Operation
- Prescaler: 16-bit counter runs 0..PRESCALE-1, then wraps to 0.
  - tick = 1 in the cycle the prescaler equals PRESCALE-1.
- PWM counter: 8-bit pwm_cnt increments on tick and wraps 255→0.
  - frame = tick && pwm_cnt==255.
- Brightness bright[i], 8 bits per channel, updates only on frame, using led_req sampled in that same cycle.
  - led_req[i]=1: bright ← min(255, bright+STEP), computed in 9 bits, then saturated.
  - led_req[i]=0: bright ← max(0, bright−STEP), computed signed, then clamped.
  - Any led_req change between frames has no effect until the next frame.
- Per-channel state is implied by bright and led_req: DARK (bright=0, req=0), RISING, LIT (bright=255, req=1), FALLING.
  - A request reversal mid-ramp reverses direction at the next frame, starting from the current bright; there is no restart from an endpoint.
- duty[i] = bright[i] (see Configuration).
- leds[i] ← (duty[i]==255) || (pwm_cnt < duty[i]), registered every cycle.
  - duty 0 → pin constantly 0.
  - duty 255 → pin constantly 1.
- fading[i] ← (led_req[i] && bright[i]!=255) || (!led_req[i] && bright[i]!=0), registered every cycle.
- blink ← blink_in, sampled on frame only.

## Timing
- Reset values when rst_n=0 at a clock edge: prescaler 0, pwm_cnt 0, all bright 0, leds 6'b0, blink 0, fading 6'b0.
- Reset mid-ramp discards all progress. The first frame after release occurs 256·PRESCALE cycles after the first non-reset edge.
- leds latency: 1 cycle from a pwm_cnt/duty change.
- fading latency: 1 cycle after a led_req or bright change.
- Full ramp, 0→255 or 255→0: ceil(255/STEP) frames; default 64 frames, about 0.64 s.
- Frame length: 256·PRESCALE cycles exactly; no jitter.
- PRESCALE=1: tick is high every cycle and pwm_cnt increments every cycle.
- A led_req change in the same cycle as frame is used for that frame's update.

## Configuration
- LED_FADER_GAMMA_EN defined:
  - duty[i] = (bright[i]·bright[i])>>8, with duty forced to 255 when bright=255.
  - Perceptually linear fade.
  - Adds one registered pipeline stage on duty; leds latency from a bright change becomes 2 cycles.
- LED_FADER_GAMMA_EN undefined: duty[i] = bright[i], linear fade, 1-cycle latency.

## Test plan
- Reset: PRESCALE=1, hold rst_n=0 for 3 cycles with led_req=6'h3F → leds=0, fading=0, blink=0 throughout; after release, fading=6'h3F within 1 cycle.
- Rise ramp: PRESCALE=1, STEP=4, led_req=6'h01.
  - After 1 frame, ch0 high for 4 of 256 cycles.
  - After 64 frames, ch0 constantly high and fading[0]=0.
  - Channels 1-5 stay 0.
- Saturation: STEP=100, led_req=1 → bright sequence 100, 200, 255, 255. Then req=0 → 155, 55, 0, 0, with no wrap.
- Reversal: STEP=4; after 10 rising frames (bright 40), drop req[0] → next frame bright 36; fading[0] stays 1 until bright reaches 0.
- Frame alignment: toggle led_req and blink_in mid-frame, then revert before the frame → bright and blink unchanged. Toggle exactly on the frame cycle → change is taken.
- Gamma, with LED_FADER_GAMMA_EN: bright 128 → ch high for 64 of 256 cycles; bright 255 → constantly high. Without the macro, bright 128 → 128 of 256.
